// File: rtl/seq_bin2bcd_disp_pkg.sv
// seq_bin2bcd_pkg: shared types and constants for the sequential binary-to-BCD display converter.
//   state_t        FSM states IDLE / SHIFT / FINISH
//   CODE_W         width of one per-digit display code
//   BLANK_CODE_DEF default code driven for a blanked digit
//   ovf_ref        arithmetic reference for overflow (value >= 10^digits)
package seq_bin2bcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;
  localparam int CODE_W = 6;
  localparam logic [CODE_W-1:0] BLANK_CODE_DEF = 6'b010000;
  function automatic logic ovf_ref(input longint unsigned v, input int digits);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    return v >= p;
  endfunction
endpackage

// File: rtl/seq_bin2bcd_disp_if.sv
// seq_bin2bcd_disp_if: start/done conversion bus between data source and converter.
//   start, bin, sat                       source -> converter
//   busy, done, overflow, bcd, seg_codes  converter -> display path
interface seq_bin2bcd_disp_if
  import seq_bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 6
) ();
  logic                     start;
  logic [BIN_W-1:0]         bin;
  logic                     sat;
  logic                     busy;
  logic                     done;
  logic                     overflow;
  logic [4*DIGITS-1:0]      bcd;
  logic [CODE_W*DIGITS-1:0] seg_codes;
  modport master (output start, bin, sat, input busy, done, overflow, bcd, seg_codes);
  modport slave  (input start, bin, sat, output busy, done, overflow, bcd, seg_codes);
endinterface

// File: rtl/seq_bin2bcd_disp_digit_adj.sv
// bcd_digit_adj: double-dabble digit correction, adds 3 to a BCD nibble that is 5 or more.
//   d_i  nibble before the shift
//   d_o  corrected nibble
module bcd_digit_adj (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);
  assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

// File: rtl/seq_bin2bcd_disp.sv
// seq_bin2bcd_disp: iterative double-dabble binary-to-BCD converter with display codes.
//   clk, rst  clock and asynchronous active-high reset
//   bus       slave side of seq_bin2bcd_disp_if (start/bin/sat in; busy/done/overflow/bcd/seg_codes out)
module seq_bin2bcd_disp
  import seq_bin2bcd_pkg::*;
#(
  parameter int                BIN_W      = 32,
  parameter int                DIGITS     = 6,
  parameter int                BLANK_LZ   = 1,
  parameter logic [CODE_W-1:0] BLANK_CODE = BLANK_CODE_DEF
) (
  input logic              clk,
  input logic              rst,
  seq_bin2bcd_disp_if.slave bus
);
  localparam int BW = 4*DIGITS;
  localparam int SW = BW + BIN_W;
  localparam int CW = $clog2(BIN_W+1);
  state_t                   state_q, state_d;
  logic [SW-1:0]            sr_q, sr_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     sat_q, sat_d;
  logic                     acc_q, acc_d;
  logic [BW-1:0]            bcd_q, bcd_d;
  logic                     ovf_q, ovf_d;
  logic [CODE_W*DIGITS-1:0] seg_q, seg_d;
  logic                     done_q, done_d;
  logic [BW-1:0]            adj;
  logic [SW-1:0]            shifted;
  // Digit k>0 blanks only while it and every digit above it are zero; applied to 0 this
  // also yields the reset pattern.
  function automatic logic [CODE_W*DIGITS-1:0] seg_of(input logic [BW-1:0] b);
    logic hz;
    hz = 1'b1;
    seg_of = '0;
    for (int k = DIGITS-1; k >= 0; k--) begin
      hz = hz & (b[4*k +: 4] == 4'd0);
      seg_of[CODE_W*k +: CODE_W] = (BLANK_LZ != 0 && k > 0 && hz) ? BLANK_CODE : {2'b00, b[4*k +: 4]};
    end
  endfunction
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (.d_i(sr_q[BIN_W+4*g +: 4]), .d_o(adj[4*g +: 4]));
  end
  assign shifted = {adj[BW-2:0], sr_q[BIN_W-1:0], 1'b0};
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    acc_d   = acc_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    seg_d   = seg_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        sr_d    = {{BW{1'b0}}, bus.bin};
        sat_d   = bus.sat;
        acc_d   = 1'b0;
        cnt_d   = CW'(BIN_W);
        state_d = SHIFT;
      end
      SHIFT: begin
        sr_d    = shifted;
        // A bit leaving the top digit is a dropped 10^DIGITS carry.
        acc_d   = acc_q | adj[BW-1];
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == CW'(1)) ? FINISH : SHIFT;
      end
      FINISH: begin
        bcd_d   = (sat_q && acc_q) ? {DIGITS{4'd9}} : sr_q[SW-1:BIN_W];
        ovf_d   = acc_q;
        seg_d   = seg_of(bcd_d);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      acc_q   <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      seg_q   <= seg_of('0);
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      acc_q   <= acc_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      seg_q   <= seg_d;
      done_q  <= done_d;
    end
  end
  assign bus.busy      = state_q != IDLE;
  assign bus.done      = done_q;
  assign bus.overflow  = ovf_q;
  assign bus.bcd       = bcd_q;
  assign bus.seg_codes = seg_q;
endmodule

// File: tb/tb_seq_bin2bcd_disp.sv
// tb_seq_bin2bcd_disp: randomized and directed checks of seq_bin2bcd_disp against a decimal model.
module tb_seq_bin2bcd_disp;
  import seq_bin2bcd_pkg::*;
  localparam int LAT = 33;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vecs = 0;
  int   errs = 0;
  logic [31:0] vals [10] = '{32'd123456, 32'd1234567, 32'd1234567, 32'd42, 32'd0,
                             32'hFFFFFFFF, 32'd999999, 32'd1000000, 32'hFFFFFFFF, 32'd9};
  logic        sats [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  seq_bin2bcd_disp_if #(.BIN_W(32), .DIGITS(6)) bus ();
  seq_bin2bcd_disp #(.BIN_W(32), .DIGITS(6), .BLANK_LZ(1), .BLANK_CODE(6'b010000)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  // Decimal reference: wrapped or saturated value, its digits, and blanking by magnitude.
  function automatic void model(input logic [31:0] v, input logic s,
                                output logic [23:0] eb, output logic eo, output logic [35:0] es);
    longint unsigned r, p;
    logic [3:0] d;
    eo = ovf_ref({32'd0, v}, 6);
    r  = (s && eo) ? 64'd999999 : {32'd0, v} % 64'd1000000;
    p  = 1;
    for (int k = 0; k < 6; k++) begin
      d = 4'((r / p) % 10);
      eb[4*k +: 4] = d;
      es[6*k +: 6] = (k > 0 && r < p) ? 6'b010000 : {2'b00, d};
      p = p * 10;
    end
  endfunction
  // Issues one start and waits (bounded) for done; lat counts clock edges after the accept edge.
  task automatic convert(input logic [31:0] v, input logic s, output int lat);
    @(negedge clk);
    bus.start = 1'b1; bus.bin = v; bus.sat = s;
    @(posedge clk);
    #1 bus.start = 1'b0; bus.bin = $urandom; bus.sat = ~s;
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) begin lat = n; break; end
    end
  endtask
  task automatic test_reset();
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    vecs++; if (bus.done !== 1'b0) begin errs++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    vecs++; if (bus.overflow !== 1'b0) begin errs++; $display("FAIL reset_ovf: got %b expected 0", bus.overflow); end
    vecs++; if (bus.bcd !== 24'h0) begin errs++; $display("FAIL reset_bcd: got %h expected 000000", bus.bcd); end
    vecs++; if (bus.seg_codes !== {{5{6'b010000}}, 6'b0}) begin
      errs++; $display("FAIL reset_seg: got %h expected %h", bus.seg_codes, {{5{6'b010000}}, 6'b0});
    end
  endtask
  task automatic test_convert();
    logic [31:0] v; logic s; logic [23:0] eb; logic eo; logic [35:0] es; int lat;
    for (int i = 0; i < 40; i++) begin
      v = (i < 10) ? vals[i] : (($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 1999999));
      s = (i < 10) ? sats[i] : 1'($urandom_range(0, 1));
      model(v, s, eb, eo, es);
      convert(v, s, lat);
      vecs++; if (lat !== LAT) begin errs++; $display("FAIL latency bin=%0d: got %0d expected %0d", v, lat, LAT); end
      vecs++; if (bus.bcd !== eb) begin errs++; $display("FAIL bcd bin=%0d sat=%b: got %h expected %h", v, s, bus.bcd, eb); end
      vecs++; if (bus.overflow !== eo) begin errs++; $display("FAIL overflow bin=%0d: got %b expected %b", v, bus.overflow, eo); end
      vecs++; if (bus.seg_codes !== es) begin errs++; $display("FAIL seg bin=%0d sat=%b: got %h expected %h", v, s, bus.seg_codes, es); end
      @(negedge clk);
      vecs++; if (bus.done !== 1'b0) begin errs++; $display("FAIL done_pulse bin=%0d: got %b expected 0", v, bus.done); end
    end
  endtask
  task automatic test_ignore_busy();
    logic [23:0] eb; logic eo; logic [35:0] es; int n_done, lat;
    model(32'd777001, 1'b0, eb, eo, es);
    @(negedge clk);
    bus.start = 1'b1; bus.bin = 32'd777001; bus.sat = 1'b0;
    @(posedge clk);
    #1 bus.start = 1'b0; bus.bin = 32'd5; bus.sat = 1'b1;
    n_done = 0; lat = -1;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) begin n_done++; lat = n; end
      if (n == 5) begin
        vecs++; if (bus.busy !== 1'b1) begin errs++; $display("FAIL busy_mid: got %b expected 1", bus.busy); end
      end
      bus.start = (n == 5 || n == 10);
    end
    vecs++; if (n_done !== 1) begin errs++; $display("FAIL ignore_done_count: got %0d expected 1", n_done); end
    vecs++; if (lat !== LAT) begin errs++; $display("FAIL ignore_latency: got %0d expected %0d", lat, LAT); end
    vecs++; if (bus.bcd !== eb) begin errs++; $display("FAIL ignore_bcd: got %h expected %h", bus.bcd, eb); end
  endtask
  task automatic test_back_to_back();
    logic [31:0] v2; logic [23:0] eb; logic eo; logic [35:0] es; int lat;
    v2 = $urandom;
    convert(32'd314159, 1'b0, lat);
    vecs++; if (lat !== LAT) begin errs++; $display("FAIL b2b_first_latency: got %0d expected %0d", lat, LAT); end
    bus.start = 1'b1; bus.bin = v2; bus.sat = 1'b0;
    @(posedge clk);
    #1 bus.start = 1'b0; bus.bin = 32'd0;
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) begin lat = n; break; end
    end
    model(v2, 1'b0, eb, eo, es);
    vecs++; if (lat !== LAT) begin errs++; $display("FAIL b2b_latency: got %0d expected %0d", lat, LAT); end
    vecs++; if (bus.bcd !== eb) begin errs++; $display("FAIL b2b_bcd bin=%0d: got %h expected %h", v2, bus.bcd, eb); end
    vecs++; if (bus.overflow !== eo) begin errs++; $display("FAIL b2b_overflow: got %b expected %b", bus.overflow, eo); end
  endtask
  task automatic test_reset_mid();
    logic [23:0] eb; logic eo; logic [35:0] es; int lat, n_done;
    convert(32'd1234567, 1'b0, lat);
    vecs++; if (bus.overflow !== 1'b1) begin errs++; $display("FAIL pre_reset_ovf: got %b expected 1", bus.overflow); end
    @(negedge clk);
    bus.start = 1'b1; bus.bin = 32'd555; bus.sat = 1'b0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (15) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL rst_mid_busy: got %b expected 0", bus.busy); end
    vecs++; if (bus.done !== 1'b0) begin errs++; $display("FAIL rst_mid_done: got %b expected 0", bus.done); end
    vecs++; if (bus.overflow !== 1'b0) begin errs++; $display("FAIL rst_mid_ovf: got %b expected 0", bus.overflow); end
    vecs++; if (bus.bcd !== 24'h0) begin errs++; $display("FAIL rst_mid_bcd: got %h expected 000000", bus.bcd); end
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    vecs++; if (n_done !== 0) begin errs++; $display("FAIL rst_mid_no_done: got %0d expected 0", n_done); end
    model(32'd2024, 1'b0, eb, eo, es);
    convert(32'd2024, 1'b0, lat);
    vecs++; if (lat !== LAT) begin errs++; $display("FAIL post_rst_latency: got %0d expected %0d", lat, LAT); end
    vecs++; if (bus.bcd !== eb) begin errs++; $display("FAIL post_rst_bcd: got %h expected %h", bus.bcd, eb); end
    vecs++; if (bus.seg_codes !== es) begin errs++; $display("FAIL post_rst_seg: got %h expected %h", bus.seg_codes, es); end
  endtask
  initial begin
    bus.start = 1'b0; bus.bin = '0; bus.sat = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_convert();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
